// File: rtl/pss_peak_tracker.sv
// pss_peak_tracker
// Follows the periodic PSS correlation peaks in a sample stream. The block
// forwards the stream with one cycle of delay and reports these events:
//   - accepted peaks,
//   - missed windows,
//   - the lock state,
//   - the timing offset of the last accepted peak against the nominal period.
//
// Timing is counted in valid samples only. The index counter holds the index
// of the sample currently on the input: the anchor sample (the last accepted
// or candidate peak) has index 0.
//
// The acceptance window covers indexes PERIOD-TOL .. PERIOD+TOL inclusive.
// Parameter legality is the integrator's responsibility:
//   - PERIOD > 2*TOL+1
//   - 1 <= MAX_MISSES <= 15

module pss_peak_tracker #(
    parameter int IN_DW      = 32,
    parameter int PERIOD     = 9600,
    parameter int TOL        = 4,
    parameter int MAX_MISSES = 3
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [IN_DW-1:0]             s_axis_in_tdata,
    input  logic                         s_axis_in_tvalid,
    input  logic                         peak_detected_i,
    output logic [IN_DW-1:0]             m_axis_out_tdata,
    output logic                         m_axis_out_tvalid,
    output logic                         peak_valid_o,
    output logic                         miss_o,
    output logic                         locked_o,
    output logic signed [$clog2(TOL+1):0] offset_o,
    output logic [3:0]                   miss_count_o
);

    // Index counter width: PERIOD+TOL must be representable, with one spare bit.
    localparam int CW = $clog2(PERIOD + TOL + 1) + 1;
    // Offset width: signed range -TOL .. +TOL.
    localparam int OW = $clog2(TOL + 1) + 1;

    localparam logic [CW-1:0] WIN_LO     = CW'(PERIOD - TOL);
    localparam logic [CW-1:0] WIN_HI     = CW'(PERIOD + TOL);
    // After a miss the anchor moves to the nominal PERIOD position. The sample
    // following index PERIOD+TOL therefore gets index TOL+1.
    localparam logic [CW-1:0] RELOCK_IDX = CW'(TOL + 1);
    localparam logic [CW-1:0] IDX_ONE    = CW'(1);
    localparam logic [CW-1:0] IDX_MAX    = '1;
    localparam logic signed [CW:0] PERIOD_S = (CW + 1)'(PERIOD);
    localparam logic [3:0]    MISS_LIMIT = 4'(MAX_MISSES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CW-1:0]       idx_q;
    logic [CW-1:0]       idx_d;
    logic [CW-1:0]       idx_inc;
    logic [3:0]          miss_cnt_d;
    logic [3:0]          miss_inc;
    logic signed [OW-1:0] offset_d;
    logic signed [OW-1:0] offset_here;
    logic                peak_valid_d;
    logic                miss_d;
    logic                in_window;
    logic                before_window;
    logic                at_window_end;

    // Decode where the current sample sits relative to the window.
    always_comb begin
        in_window     = (idx_q >= WIN_LO) && (idx_q <= WIN_HI);
        before_window = (idx_q < WIN_LO);
        at_window_end = (idx_q == WIN_HI);
        // The counter saturates instead of wrapping. In normal operation it
        // never passes PERIOD+TOL.
        idx_inc       = (idx_q == IDX_MAX) ? idx_q : idx_q + IDX_ONE;
        miss_inc      = (miss_count_o == 4'hF) ? miss_count_o : miss_count_o + 4'd1;
        offset_here   = OW'($signed({1'b0, idx_q}) - PERIOD_S);
    end

    // Next-state, counter and status-pulse logic for one valid sample.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        idx_d        = idx_q;
        miss_cnt_d   = miss_count_o;
        offset_d     = offset_o;
        peak_valid_d = 1'b0;
        miss_d       = 1'b0;

        if (s_axis_in_tvalid) begin
            idx_d = idx_inc;
            unique case (state_q)
                SEARCH: begin
                    if (peak_detected_i) begin
                        // This peak becomes the candidate anchor. It is not
                        // reported yet.
                        state_d = CONFIRM;
                        idx_d   = IDX_ONE;
                    end else begin
                        idx_d = '0;
                    end
                end

                CONFIRM: begin
                    if (peak_detected_i && in_window) begin
                        state_d      = LOCKED;
                        idx_d        = IDX_ONE;
                        peak_valid_d = 1'b1;
                        offset_d     = offset_here;
                        miss_cnt_d   = 4'd0;
                    end else if (peak_detected_i && before_window) begin
                        // An early peak replaces the candidate.
                        idx_d = IDX_ONE;
                    end else if (at_window_end) begin
                        // The candidate was not confirmed. Drop it silently.
                        state_d = SEARCH;
                        idx_d   = '0;
                    end
                end

                LOCKED: begin
                    if (peak_detected_i && in_window) begin
                        idx_d        = IDX_ONE;
                        peak_valid_d = 1'b1;
                        offset_d     = offset_here;
                        miss_cnt_d   = 4'd0;
                    end else if (at_window_end) begin
                        // The window closed empty. Keep the nominal cadence.
                        miss_d     = 1'b1;
                        miss_cnt_d = miss_inc;
                        idx_d      = RELOCK_IDX;
                        if (miss_inc >= MISS_LIMIT) begin
                            state_d = SEARCH;
                            idx_d   = '0;
                        end
                    end
                    // Peaks outside the window are ignored.
                end

                default: begin
                    state_d = SEARCH;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State and index registers.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples the values from before the edge.
        if (reset_i) begin
            state_q <= SEARCH;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Output registers: one cycle of latency for data and status alike.
    always_ff @(posedge clk_i) begin
        // NOTE: the reset clears the data path as well, so m_axis_out_tdata
        // reads as zero after reset.
        if (reset_i) begin
            m_axis_out_tdata  <= '0;
            m_axis_out_tvalid <= 1'b0;
            peak_valid_o      <= 1'b0;
            miss_o            <= 1'b0;
            locked_o          <= 1'b0;
            offset_o          <= '0;
            miss_count_o      <= 4'd0;
        end else begin
            m_axis_out_tdata  <= s_axis_in_tdata;
            m_axis_out_tvalid <= s_axis_in_tvalid;
            peak_valid_o      <= peak_valid_d;
            miss_o            <= miss_d;
            locked_o          <= (state_d == LOCKED);
            offset_o          <= offset_d;
            miss_count_o      <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_pss_peak_tracker.sv
// Self-checking bench for pss_peak_tracker.
// The reference model tracks the absolute anchor position in valid samples.
// A sample's index is its distance from that anchor.

module tb_pss_peak_tracker;

    localparam int IN_DW      = 32;
    localparam int PERIOD     = 100;
    localparam int TOL        = 2;
    localparam int MAX_MISSES = 2;
    localparam int OW         = $clog2(TOL + 1) + 1;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic [IN_DW-1:0]     s_axis_in_tdata;
    logic                 s_axis_in_tvalid;
    logic                 peak_detected_i;
    logic [IN_DW-1:0]     m_axis_out_tdata;
    logic                 m_axis_out_tvalid;
    logic                 peak_valid_o;
    logic                 miss_o;
    logic                 locked_o;
    logic signed [OW-1:0] offset_o;
    logic [3:0]           miss_count_o;

    pss_peak_tracker #(
        .IN_DW     (IN_DW),
        .PERIOD    (PERIOD),
        .TOL       (TOL),
        .MAX_MISSES(MAX_MISSES)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .s_axis_in_tdata  (s_axis_in_tdata),
        .s_axis_in_tvalid (s_axis_in_tvalid),
        .peak_detected_i  (peak_detected_i),
        .m_axis_out_tdata (m_axis_out_tdata),
        .m_axis_out_tvalid(m_axis_out_tvalid),
        .peak_valid_o     (peak_valid_o),
        .miss_o           (miss_o),
        .locked_o         (locked_o),
        .offset_o         (offset_o),
        .miss_count_o     (miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    typedef enum {M_SEARCH, M_CONFIRM, M_LOCKED} mstate_t;
    mstate_t m_state;
    int      m_n;        // valid samples seen since reset
    int      m_anchor;   // absolute valid-sample number of the anchor
    int      m_misses;
    int      m_offset;

    logic             e_tvalid;
    logic             e_pv;
    logic             e_miss;
    logic [IN_DW-1:0] e_data;

    // Per-phase bookkeeping, in valid samples counted from the phase start.
    int   phase_idx;
    int   peak_pos[$];
    int   pv_pos[$];
    int   miss_pos[$];
    int   lock_pos[$];
    int   unlock_pos[$];
    logic prev_locked;
    int   exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_pos(input string tag, input int got[$], input int exp[$]);
        check({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check({tag, "_at"}, 64'(got[i]), 64'(exp[i]));
    endtask

    task automatic model_reset();
        m_state  = M_SEARCH;
        m_n      = 0;
        m_anchor = 0;
        m_misses = 0;
        m_offset = 0;
    endtask

    task automatic model_step(input logic v, input logic pk, input logic [IN_DW-1:0] d);
        int  idx;
        bit  win;
        e_tvalid = v;
        e_data   = d;
        e_pv     = 1'b0;
        e_miss   = 1'b0;
        if (v) begin
            idx = m_n - m_anchor;
            win = (idx >= PERIOD - TOL) && (idx <= PERIOD + TOL);
            case (m_state)
                M_SEARCH: begin
                    if (pk) begin
                        m_anchor = m_n;
                        m_state  = M_CONFIRM;
                    end
                end
                M_CONFIRM: begin
                    if (pk && win) begin
                        m_anchor = m_n;
                        m_state  = M_LOCKED;
                        e_pv     = 1'b1;
                        m_offset = idx - PERIOD;
                        m_misses = 0;
                    end else if (pk && idx < PERIOD - TOL) begin
                        m_anchor = m_n;
                    end else if (idx >= PERIOD + TOL) begin
                        m_state = M_SEARCH;
                    end
                end
                M_LOCKED: begin
                    if (pk && win) begin
                        m_anchor = m_n;
                        e_pv     = 1'b1;
                        m_offset = idx - PERIOD;
                        m_misses = 0;
                    end else if (idx == PERIOD + TOL) begin
                        e_miss   = 1'b1;
                        m_misses = m_misses + 1;
                        m_anchor = m_anchor + PERIOD;
                        if (m_misses == MAX_MISSES) m_state = M_SEARCH;
                    end
                end
                default: m_state = M_SEARCH;
            endcase
            m_n++;
        end
    endtask

    function automatic bit is_peak(input int i);
        foreach (peak_pos[k]) if (peak_pos[k] == i) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic v, input logic pk);
        logic [IN_DW-1:0] d;
        logic [OW-1:0]    e_off;
        int               here;
        d                = $urandom;
        here             = phase_idx;
        s_axis_in_tvalid = v;
        peak_detected_i  = pk;
        s_axis_in_tdata  = d;
        model_step(v, pk, d);
        if (v) phase_idx++;
        @(posedge clk_i);
        #1;
        e_off = m_offset[OW-1:0];
        check("tvalid", {63'b0, m_axis_out_tvalid}, {63'b0, e_tvalid});
        if (e_tvalid) check("tdata", {32'b0, m_axis_out_tdata}, {32'b0, e_data});
        check("peak_valid", {63'b0, peak_valid_o}, {63'b0, e_pv});
        check("miss", {63'b0, miss_o}, {63'b0, e_miss});
        check("locked", {63'b0, locked_o}, {63'b0, (m_state == M_LOCKED)});
        check("offset", {{(64-OW){1'b0}}, offset_o}, {{(64-OW){1'b0}}, e_off});
        check("miss_count", {60'b0, miss_count_o}, 64'(m_misses));
        if (m_axis_out_tvalid && peak_valid_o) pv_pos.push_back(here);
        if (m_axis_out_tvalid && miss_o) miss_pos.push_back(here);
        if (locked_o && !prev_locked) lock_pos.push_back(here);
        if (!locked_o && prev_locked) unlock_pos.push_back(here);
        prev_locked = locked_o;
    endtask

    task automatic run_phase(input int n_valid, input int valid_pct);
        pv_pos.delete();
        miss_pos.delete();
        lock_pos.delete();
        unlock_pos.delete();
        phase_idx = 0;
        while (phase_idx < n_valid) begin
            if ($urandom_range(99) < valid_pct) drive(1'b1, is_peak(phase_idx));
            else drive(1'b0, 1'($urandom_range(1)));
        end
    endtask

    // Applies reset for one edge while presenting a valid peak, which the DUT
    // must not report.
    task automatic do_reset();
        reset_i          = 1'b1;
        s_axis_in_tvalid = 1'b1;
        peak_detected_i  = 1'b1;
        s_axis_in_tdata  = $urandom;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        model_reset();
        prev_locked = 1'b0;
        check("rst_tvalid", {63'b0, m_axis_out_tvalid}, 64'd0);
        check("rst_tdata", {32'b0, m_axis_out_tdata}, 64'd0);
        check("rst_peak_valid", {63'b0, peak_valid_o}, 64'd0);
        check("rst_miss", {63'b0, miss_o}, 64'd0);
        check("rst_locked", {63'b0, locked_o}, 64'd0);
        check("rst_offset", {{(64-OW){1'b0}}, offset_o}, 64'd0);
        check("rst_miss_count", {60'b0, miss_count_o}, 64'd0);
    endtask

    initial begin
        int p;
        reset_i          = 1'b1;
        s_axis_in_tvalid = 1'b0;
        peak_detected_i  = 1'b0;
        s_axis_in_tdata  = '0;
        prev_locked      = 1'b0;
        model_reset();

        // Step 1: reset state.
        do_reset();

        // Step 2: peaks at 0, 100 and 200 lock at 100 with zero offset.
        peak_pos = '{0, 100, 200};
        run_phase(201, 100);
        exp_q = '{100, 200}; check_pos("s2_pv", pv_pos, exp_q);
        exp_q = '{100};      check_pos("s2_lock", lock_pos, exp_q);
        check("s2_offset", {{(64-OW){1'b0}}, offset_o}, 64'd0);

        // Step 3: a late peak at index 102 is accepted with offset +2.
        do_reset();
        peak_pos = '{0, 100, 202};
        run_phase(203, 100);
        exp_q = '{100, 202}; check_pos("s3_pv", pv_pos, exp_q);
        check("s3_offset", {{(64-OW){1'b0}}, offset_o}, 64'd2);

        // Step 4: a peak at index 103 is ignored, and the miss lands on index 102.
        do_reset();
        peak_pos = '{0, 100, 203};
        run_phase(210, 100);
        exp_q = '{100}; check_pos("s4_pv", pv_pos, exp_q);
        exp_q = '{202}; check_pos("s4_miss", miss_pos, exp_q);
        check("s4_miss_count", {60'b0, miss_count_o}, 64'd1);
        check("s4_locked", {63'b0, locked_o}, 64'd1);

        // Step 5: no peaks after lock. Two misses occur, and the lock drops on the second.
        do_reset();
        peak_pos = '{0, 100};
        run_phase(310, 100);
        exp_q = '{202, 302}; check_pos("s5_miss", miss_pos, exp_q);
        exp_q = '{302};      check_pos("s5_unlock", unlock_pos, exp_q);
        check("s5_miss_count", {60'b0, miss_count_o}, 64'd2);
        check("s5_locked", {63'b0, locked_o}, 64'd0);

        // Step 6: an early peak at 50 replaces the candidate, and the tracker locks at 150.
        do_reset();
        peak_pos = '{0, 50, 150};
        run_phase(160, 100);
        exp_q = '{150}; check_pos("s6_pv", pv_pos, exp_q);
        exp_q = '{150}; check_pos("s6_lock", lock_pos, exp_q);
        check("s6_offset", {{(64-OW){1'b0}}, offset_o}, 64'd0);

        // Step 7: the same pattern, all-valid and then with 50% valid. Pulses
        // fall on the same valid-sample positions in both runs.
        do_reset();
        peak_pos = '{0, 100, 200};
        run_phase(410, 100);
        exp_q = '{100, 200}; check_pos("s7a_pv", pv_pos, exp_q);
        exp_q = '{302, 402}; check_pos("s7a_miss", miss_pos, exp_q);
        do_reset();
        run_phase(410, 50);
        exp_q = '{100, 200}; check_pos("s7b_pv", pv_pos, exp_q);
        exp_q = '{302, 402}; check_pos("s7b_miss", miss_pos, exp_q);
        exp_q = '{402};      check_pos("s7b_unlock", unlock_pos, exp_q);

        // Step 8: reset at index 60 while locked. A peak at 40 afterwards
        // restarts CONFIRM.
        do_reset();
        peak_pos = '{0, 100, 200};
        run_phase(261, 100);
        check("s8_locked_before", {63'b0, locked_o}, 64'd1);
        do_reset();
        peak_pos = '{40, 140};
        run_phase(150, 100);
        exp_q = '{140}; check_pos("s8_pv", pv_pos, exp_q);
        exp_q = '{140}; check_pos("s8_lock", lock_pos, exp_q);

        // Step 9: randomized run with jittered peaks, dropouts and spurious peaks.
        do_reset();
        peak_pos.delete();
        p = 0;
        while (p < 2500) begin
            if ($urandom_range(4) != 0) peak_pos.push_back(p);
            p = p + PERIOD + int'($urandom_range(6)) - 3;
        end
        for (int k = 0; k < 30; k++) peak_pos.push_back(int'($urandom_range(2499)));
        run_phase(2500, 85);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pss_peak_tracker.md
PSS_PEAK_TRACKER -- requirements
Module: pss_peak_tracker

Interface
REQ-001 SHALL have parameter IN_DW, default 32, meaning sample data width.
REQ-002 SHALL have parameter PERIOD, default 9600, meaning nominal valid-sample count between PSS peaks.
REQ-003 SHALL have parameter TOL, default 4, meaning accepted peak deviation in samples; PERIOD > 2*TOL+1 is required.
REQ-004 SHALL have parameter MAX_MISSES, default 3, meaning consecutive missed windows before lock loss, range 1..15.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port s_axis_in_tdata, input, IN_DW bits: sample stream, aligned with the peak flag.
REQ-008 SHALL have port s_axis_in_tvalid, input, 1 bit: sample qualifier.
REQ-009 SHALL have port peak_detected_i, input, 1 bit: peak-detector flag for the current sample.
REQ-010 SHALL have port m_axis_out_tdata, output, IN_DW bits: delayed sample.
REQ-011 SHALL have port m_axis_out_tvalid, output, 1 bit: delayed qualifier.
REQ-012 SHALL have port peak_valid_o, output, 1 bit: accepted peak, aligned with its output sample.
REQ-013 SHALL have port miss_o, output, 1 bit: expected window closed without a peak.
REQ-014 SHALL have port locked_o, output, 1 bit: tracker is in LOCKED.
REQ-015 SHALL have port offset_o, output, signed $clog2(TOL+1)+1 bits: last accepted peak index minus PERIOD.
REQ-016 SHALL have port miss_count_o, output, 4 bits: consecutive misses.

Function
REQ-017 SHALL register every output, giving exactly 1 cycle latency from input to m_axis_out_* and to the status pulses.
REQ-018 SHALL ignore peak_detected_i and advance no counter on cycles with s_axis_in_tvalid low.
- On those cycles m_axis_out_tvalid=0, peak_valid_o=0 and miss_o=0.
REQ-019 SHALL keep an index counter: the anchor sample has index 0, and each later valid sample increments it by 1.
- Width is $clog2(PERIOD+TOL+1)+1 bits.
- The counter never wraps.
REQ-020 SHALL define the acceptance window as indexes PERIOD-TOL through PERIOD+TOL inclusive.
REQ-021 SHALL implement states SEARCH, CONFIRM and LOCKED; reset enters SEARCH.
REQ-022 In SEARCH, a valid peak SHALL set the anchor (index 0) and move to CONFIRM.
- peak_valid_o stays 0.
REQ-023 In CONFIRM, the behaviour SHALL be:
- Peak inside the window: re-anchor, go to LOCKED, pulse peak_valid_o, load offset_o.
- Peak before the window: re-anchor and stay in CONFIRM, since it is a new candidate.
- Index passes PERIOD+TOL with no peak: go to SEARCH, with no miss_o.
REQ-024 In LOCKED, the first valid peak inside the window SHALL be handled as follows:
- re-anchor;
- pulse peak_valid_o;
- load offset_o;
- clear miss_count_o.
REQ-025 In LOCKED, peaks outside the window SHALL be ignored, including a second peak after re-anchoring.
REQ-026 In LOCKED, when the sample at index PERIOD+TOL carries no peak, the tracker SHALL:
- pulse miss_o;
- increment miss_count_o;
- set the next valid sample's index to TOL+1, i.e. anchor at the nominal PERIOD.
REQ-027 When a miss makes miss_count_o equal MAX_MISSES, the tracker SHALL go to SEARCH.
- locked_o falls with that same miss_o pulse.
- miss_count_o holds its value until the next entry into LOCKED clears it.
REQ-028 A peak at index PERIOD+TOL SHALL count as a hit; no miss_o is produced for that sample.
REQ-029 locked_o SHALL be 1 exactly while the state is LOCKED, changing with the output of the transitioning sample.
REQ-030 offset_o SHALL hold its value between accepted peaks.

Reset
REQ-031 On reset_i high at a clock edge, the block SHALL take:
- state SEARCH;
- counter 0;
- all outputs 0, including m_axis_out_tdata;
- offset_o 0 and miss_count_o 0.
REQ-032 Reset asserted mid-window SHALL discard the anchor and any pending confirmation; no pulse is emitted on the cycle after reset.

Verification
Use PERIOD=100, TOL=2, MAX_MISSES=2 unless stated otherwise.
REQ-033 Bench SHALL check: peaks at valid samples 0, 100 and 200 -> locked_o rises with the output of sample 100; peak_valid_o pulses at 100 and 200; offset_o=0.
REQ-034 Bench SHALL check: lock, then the next peak at index 102 -> peak_valid_o pulses and offset_o=+2; a peak at index 103 instead -> ignored, miss_o pulses at index 102.
REQ-035 Bench SHALL check: lock, then no further peaks -> miss_o at indexes 102 and 202 relative to the last anchor; miss_count_o goes 1 then 2; locked_o falls with the second miss.
REQ-036 Bench SHALL check: first candidate at 0, then peaks at 50 and 150 -> the candidate moves to 50 and locks at 150 with offset_o=0.
REQ-037 Bench SHALL check: locked, s_axis_in_tvalid toggled 50% -> the index advances only on valid samples, and pulse positions match the all-valid run counted in valid samples.
REQ-038 Bench SHALL check: reset_i asserted at index 60 while locked -> all outputs 0 on the next cycle; a peak at index 40 after reset restarts CONFIRM.
